// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: radix-2 Booth multiply, non-restoring divide.
// Fixed 33-cycle latency from the start edge to the registered result and one-cycle ready pulse.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // Two guard bits keep Booth add/sub of the most negative multiplicand and the
    // non-restoring partial remainder from overflowing.
    localparam int unsigned HW = WIDTH + 2;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMult, StDiv, StFin, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic             start;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [HW-1:0]    opnd_sext, opnd_zext;
    logic [HW-1:0]    booth_sum, div_shift, div_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   prod_top;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign opnd_sext = {{2{opnd_q[WIDTH-1]}}, opnd_q};
    assign opnd_zext = {2'b00, opnd_q};
    assign product   = {hi_q[WIDTH-1:0], lo_q};
    assign prod_top  = product[2*WIDTH-1:WIDTH-1];

    always_comb begin
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + opnd_sext;
            2'b10:   booth_sum = hi_q - opnd_sext;
            default: booth_sum = hi_q;
        endcase
    end

    // Add back instead of restoring when the partial remainder went negative.
    assign div_shift = {hi_q[HW-2:0], lo_q[WIDTH-1]};
    assign div_next  = hi_q[HW-1] ? div_shift + opnd_zext : div_shift - opnd_zext;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;

        if (start) begin
            cnt_d = '0;
            hi_d  = '0;
            qm1_d = 1'b0;
            if (ctrl_MULT) begin
                state_d  = StMult;
                is_div_d = 1'b0;
                lo_d     = data_operandB;
                opnd_d   = data_operandA;
            end else begin
                state_d  = StDiv;
                is_div_d = 1'b1;
                lo_d     = a_mag;
                opnd_d   = b_mag;
                neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                dz_d     = (data_operandB == '0);
                ovf_d    = (data_operandA == MinVal) && (&data_operandB);
            end
        end else begin
            case (state_q)
                StMult, StDiv: begin
                    if (state_q == StMult) begin
                        hi_d  = {booth_sum[HW-1], booth_sum[HW-1:1]};
                        lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
                        qm1_d = lo_q[0];
                    end else begin
                        hi_d = div_next;
                        lo_d = {lo_q[WIDTH-2:0], ~div_next[HW-1]};
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StFin;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StFin: begin
                    state_d = StDone;
                    if (is_div_q) begin
                        exc_d = dz_q | ovf_q;
                        if (dz_q) begin
                            result_d = '0;
                        end else if (ovf_q) begin
                            result_d = MinVal;
                        end else begin
                            result_d = neg_q ? -lo_q : lo_q;
                        end
                    end else begin
                        result_d = product[WIDTH-1:0];
                        exc_d    = !((&prod_top) || !(|prod_top));
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q == StMult) || (state_q == StDiv) || (state_q == StFin);

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: vector table plus scoreboard keyed on the fixed 33-cycle latency,
// with hand-written sequences for reset, abort and simultaneous-start corner cases.
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          t0;
    } exp_t;

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;
    logic        mon_exp_rdy;
    exp_t        mon_e;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic d, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic e);
        vec_t v;
        v.is_div = d;
        v.a      = a;
        v.b      = b;
        v.res    = r;
        v.exc    = e;
        return v;
    endfunction

    // Reference arithmetic on 64-bit integers; returns {exception, result}.
    function automatic logic [32:0] model(input logic d, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      pa;
        longint      pb;
        longint      p;
        logic [63:0] pv;
        logic [32:0] top;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (!d) begin
            p   = pa * pb;
            pv  = p;
            top = pv[63:31];
            return {((top != '0) && (top != '1)), pv[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        p  = pa / pb;
        pv = p;
        return {1'b0, pv[31:0]};
    endfunction

    // Called at a negedge; the start is sampled on the following posedge.
    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic e);
        exp_t x;
        x.res = r;
        x.exc = e;
        x.t0  = cyc;
        sb.push_back(x);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    // Monitor: RDY must be high exactly 33 cycles after each scoreboarded start.
    initial begin
        forever begin
            @(negedge clock);
            if (cyc > 0) begin
                mon_exp_rdy = (sb.size() != 0) && (cyc - sb[0].t0 == 33);
                check("rdy", {31'b0, data_resultRDY}, {31'b0, mon_exp_rdy});
                if (mon_exp_rdy) begin
                    mon_e = sb.pop_front();
                    if (data_resultRDY === 1'b1) begin
                        check("result", data_result, mon_e.res);
                        check("exception", {31'b0, data_exception}, {31'b0, mon_e.exc});
                    end
                    last_res = mon_e.res;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] m;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rd;

        reset         = 1'b1;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;

        vecs.push_back(mk(1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(1'b0, 32'hFFFF_0000,  32'h0000_8000, 32'h8000_0000, 1'b0));
        vecs.push_back(mk(1'b0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1));
        vecs.push_back(mk(1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0));
        vecs.push_back(mk(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1));
        vecs.push_back(mk(1'b0, 32'd0,          32'hFFFF_FFFF, 32'h0000_0000, 1'b0));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0));
        vecs.push_back(mk(1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0));
        vecs.push_back(mk(1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1));
        vecs.push_back(mk(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1));
        vecs.push_back(mk(1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0));
        vecs.push_back(mk(1'b1, 32'h8000_0000,  32'h8000_0000, 32'd1,         1'b0));
        vecs.push_back(mk(1'b1, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0));
        vecs.push_back(mk(1'b1, 32'd3,          32'd5,         32'd0,         1'b0));
        vecs.push_back(mk(1'b1, 32'h7FFF_FFFF,  32'hFFFF_FFFF, 32'h8000_0001, 1'b0));
        for (int i = 0; i < 10; i++) begin
            rd = i[0];
            ra = (i < 4) ? 32'($urandom_range(0, 131071)) - 32'd65536 : 32'($urandom);
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 16)) - 32'd8 : 32'($urandom);
            m  = model(rd, ra, rb);
            vecs.push_back(mk(rd, ra, rb, m[31:0], m[32]));
        end

        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'b0, data_exception}, 32'd0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b);
            push_exp(vecs[i].res, vecs[i].exc);
            wait_drain();
        end

        // Busy window and result hold across a new start.
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        push_exp(32'hFFFF_FFEB, 1'b0);
        check("hold_result", data_result, last_res);
        check("busy_at_start", {31'b0, busy}, 32'd1);
        repeat (32) @(negedge clock);
        check("busy_last_iter", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("busy_at_rdy", {31'b0, busy}, 32'd0);
        wait_drain();

        // Reset mid-operation.
        issue(1'b1, 1'b0, 32'd11, 32'd13);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_result", data_result, 32'd0);
        check("midreset_exception", {31'b0, data_exception}, 32'd0);
        repeat (30) @(negedge clock);

        // Restart five cycles in: only the divide completes.
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clock);
        issue(1'b0, 1'b1, 32'd9, 32'd3);
        push_exp(32'd3, 1'b0);
        wait_drain();

        // Restart on the last iteration edge.
        issue(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (31) @(negedge clock);
        issue(1'b0, 1'b1, 32'hFFFF_FFF7, 32'd2);
        push_exp(32'hFFFF_FFFC, 1'b0);
        wait_drain();

        // Restart on the edge that would have registered the result.
        issue(1'b1, 1'b0, 32'd2, 32'd2);
        repeat (32) @(negedge clock);
        issue(1'b0, 1'b1, 32'd10, 32'd3);
        push_exp(32'd3, 1'b0);
        wait_drain();

        // Simultaneous starts: multiply wins.
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        push_exp(32'd18, 1'b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
